// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared seven-segment display constants and helpers
package seg7_scan_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: score input and multiplexed display output bundle
interface seg7_scan_if;
  import seg7_scan_pkg::*;
  logic [15:0] BCD;
  logic LZ_BLANK;
  logic [3:0] AN;
  seg_t SEG;
  logic FRAME_TICK;
  modport master(output BCD, LZ_BLANK, input AN, SEG, FRAME_TICK);
  modport slave(input BCD, LZ_BLANK, output AN, SEG, FRAME_TICK);
endinterface

// File: rtl/seg7_scan_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low segment decode, dash for 10..15
module bcd_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);
  always_comb seg = bcd > 4'd9 ? SEG_DASH : SEG_DIGIT[bcd];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed display scanner with frame snapshot, dead time and leading-zero blanking
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input logic display_clk,
  input logic RST_N,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] dig_q, dig_d;
  logic [15:0] snap_q, snap_d;
  logic lz_q, lz_d;
  logic [3:0] an_q, an_d;
  seg_t seg_q, seg_d, dec;
  logic wrap, frame, z3, z2, z1, blank;
  bcd_to_seg7 u_dec (.bcd(nibble(snap_q, dig_q)), .seg(dec));
  // a digit blanks only if it and every digit above it are exactly zero; invalid codes count as non-zero
  always_comb begin
    wrap = cnt_q == CW'(SCAN_DIV - 1);
    frame = wrap && dig_q == 2'd3;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    dig_d = wrap ? dig_q + 2'd1 : dig_q;
    snap_d = frame ? bus.BCD : snap_q;
    lz_d = frame ? bus.LZ_BLANK : lz_q;
    z3 = snap_q[15:12] == 4'd0;
    z2 = z3 && snap_q[11:8] == 4'd0;
    z1 = z2 && snap_q[7:4] == 4'd0;
    blank = lz_q && (dig_q == 2'd3 ? z3 : dig_q == 2'd2 ? z2 : dig_q == 2'd1 && z1);
    an_d = cnt_q == '0 ? AN_OFF : ~(4'b0001 << dig_q);
    seg_d = cnt_q == '0 || blank ? SEG_BLANK : dec;
  end
  always_ff @(posedge display_clk or negedge RST_N)
    if (!RST_N) begin
      cnt_q <= '0;
      dig_q <= '0;
      snap_q <= '0;
      lz_q <= 1'b0;
      an_q <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      snap_q <= snap_d;
      lz_q <= lz_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  assign bus.AN = an_q;
  assign bus.SEG = seg_q;
  assign bus.FRAME_TICK = frame;
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning the number of display_clk cycles each digit is held (minimum 2).
REQ-002 SHALL have input display_clk, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have input RST_N, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input BCD, 16 bits: packed score {d3,d2,d1,d0}, with d0 = BCD[3:0] as the rightmost digit.
REQ-005 SHALL have input LZ_BLANK, 1 bit: 1 enables leading-zero blanking.
REQ-006 SHALL have output AN, 4 bits: digit anodes, active-low, with AN[0] driving the rightmost digit.
REQ-007 SHALL have output SEG, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have output FRAME_TICK, 1 bit: one-cycle pulse at each snapshot.

Function
REQ-009 SHALL hold a dwell counter cnt that counts 0..SCAN_DIV-1 and wraps to 0.
REQ-010 SHALL advance the digit index dig (2 bits, 0→1→2→3→0) on the cycle where cnt==SCAN_DIV-1.
REQ-011 SHALL load the snapshot register snap from BCD, and pulse FRAME_TICK high for exactly one cycle, on the cycle where cnt==SCAN_DIV-1 and dig==3 (frame boundary).
REQ-012 SHALL decode only snap, never live BCD, so that a mid-frame BCD change has no visible effect until the next frame boundary (no tearing).
REQ-013 SHALL register AN and SEG; they reflect the cnt/dig/snap values of the previous cycle (1-cycle latency).
REQ-014 SHALL enforce dead time: when the previous-cycle cnt==0, the outputs are AN=4'b1111 and SEG=7'b1111111.
REQ-015 SHALL otherwise drive AN = all ones except a 0 at bit dig, and drive SEG from the decode of snap digit dig.
REQ-016 SHALL use these decode values: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.
REQ-017 SHALL decode any invalid digit value (10..15) as a dash, SEG=0111111.
REQ-018 SHALL, when LZ_BLANK=1, blank (SEG=1111111) digit k∈{3,2,1} if that digit and all higher digits of snap equal 0; digit 0 is never blanked.
REQ-019 SHALL treat an invalid digit as non-zero for blanking purposes.
REQ-020 SHALL keep the AN low-bit pattern unchanged for blanked digits; only SEG blanks.
REQ-021 SHALL sample a LZ_BLANK change at the same snapshot instant as BCD.

Reset
REQ-022 SHALL, while RST_N=0, asynchronously force cnt=0, dig=0, snap=0, the latched LZ_BLANK=0, AN=4'b1111, SEG=7'b1111111 and FRAME_TICK=0.
REQ-023 SHALL, after RST_N release, display snap=0 (digit 0 shows "0") until the first frame boundary, 4*SCAN_DIV cycles later.
REQ-024 SHALL, on a reset mid-frame, discard the partial frame; the scan restarts at dig=0.

Structure
REQ-025 SHALL place the segment constants (digit patterns, SEG_DASH, SEG_BLANK, AN_OFF) in the shared display package, for reuse by other display blocks.
REQ-026 SHALL implement the BCD-to-segment decode as a combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit out).
REQ-027 SHALL keep the dwell counter, digit index, snapshot, blanking logic and output registers in seg7_scan.

Verification (SCAN_DIV=4)
REQ-028 SHALL cover reset: assert RST_N=0 mid-scan → AN=1111, SEG=1111111 and FRAME_TICK=0 immediately; after release, the first FRAME_TICK arrives after 16 cycles.
REQ-029 SHALL cover full scan: BCD=16'h1234, LZ_BLANK=0 → after a snapshot, each 4-cycle slot shows one dead cycle then 3 cycles of AN/SEG: 1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001.
REQ-030 SHALL cover leading-zero blanking: BCD=16'h0050, LZ_BLANK=1 → digits 3 and 2 show SEG=1111111, digit 1 shows 0010010 ("5"), digit 0 shows 1000000 ("0"); for BCD=16'h0000, only digit 0 shows "0".
REQ-031 SHALL cover the invalid digit: BCD=16'h00A0, LZ_BLANK=1 → digit 1 shows 0111111 and digits 3..2 are blank.
REQ-032 SHALL cover tearing: change BCD from 16'h0009 to 16'h0010 while dig=1 → the current frame still shows 0009, and 0010 appears only after the next FRAME_TICK.
